// File: rtl/sdr_seq_divider.sv
// Sequential signed restoring divider, one quotient bit per enabled clock.
// Build option SDR_DIV_SATURATE_EN: saturate the quotient on divide-by-zero and overflow.
module sdr_seq_divider #(
    parameter int DW = 20,
    parameter int VW = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ce,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [DW-1:0] dividend,
    input  logic signed [VW-1:0] divisor,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [DW-1:0] quotient,
    output logic signed [VW-1:0] remainder,
    output logic                 div_zero,
    output logic                 overflow
);

    localparam int CW = $clog2(DW);
    localparam logic signed [DW-1:0] QMAX = {1'b0, {(DW-1){1'b1}}};

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         count_q, count_d;
    logic [DW:0]           dvdMag_q, dvdMag_d;
    logic [DW:0]           dvsMag_q, dvsMag_d;
    logic [DW:0]           rem_q, rem_d;
    logic [DW-1:0]         quo_q, quo_d;
    logic                  dvdNeg_q, dvdNeg_d;
    logic                  dvsNeg_q, dvsNeg_d;
    logic                  zero_q, zero_d;
    logic                  outValid_q, outValid_d;
    logic signed [DW-1:0]  quotient_q, quotient_d;
    logic signed [VW-1:0]  remainder_q, remainder_d;
    logic                  divZero_q, divZero_d;
    logic                  overflow_q, overflow_d;

    logic [DW:0]           dvdExt, dvsExt;
    logic [DW+1:0]         shifted;
    logic                  fits;
    logic                  qNeg;
    logic [VW-1:0]         remLow;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            count_q     <= '0;
            dvdMag_q    <= '0;
            dvsMag_q    <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvdNeg_q    <= 1'b0;
            dvsNeg_q    <= 1'b0;
            zero_q      <= 1'b0;
            outValid_q  <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            divZero_q   <= 1'b0;
            overflow_q  <= 1'b0;
        end else if (ce) begin
            state_q     <= state_d;
            count_q     <= count_d;
            dvdMag_q    <= dvdMag_d;
            dvsMag_q    <= dvsMag_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dvdNeg_q    <= dvdNeg_d;
            dvsNeg_q    <= dvsNeg_d;
            zero_q      <= zero_d;
            outValid_q  <= outValid_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            divZero_q   <= divZero_d;
            overflow_q  <= overflow_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        dvdMag_d    = dvdMag_q;
        dvsMag_d    = dvsMag_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvdNeg_d    = dvdNeg_q;
        dvsNeg_d    = dvsNeg_q;
        zero_d      = zero_q;
        outValid_d  = outValid_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        divZero_d   = divZero_q;
        overflow_d  = overflow_q;

        dvdExt  = {dividend[DW-1], dividend};
        dvsExt  = {{(DW+1-VW){divisor[VW-1]}}, divisor};
        shifted = {rem_q, dvdMag_q[DW-1]};
        fits    = shifted >= {1'b0, dvsMag_q};
        qNeg    = dvdNeg_q ^ dvsNeg_q;
        remLow  = rem_q[VW-1:0];

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    dvdMag_d = dividend[DW-1] ? -dvdExt : dvdExt;
                    dvsMag_d = divisor[VW-1] ? -dvsExt : dvsExt;
                    dvdNeg_d = dividend[DW-1];
                    dvsNeg_d = divisor[VW-1];
                    zero_d   = (divisor == '0);
                    rem_d    = '0;
                    quo_d    = '0;
                    count_d  = CW'(DW - 1);
                    state_d  = CALC;
                end
            end
            CALC: begin
                // Dividend magnitude rotates so its MSB feeds the partial remainder each step.
                dvdMag_d = {dvdMag_q[DW-1:0], dvdMag_q[DW]};
                rem_d    = fits ? (DW+1)'(shifted - {1'b0, dvsMag_q}) : shifted[DW:0];
                quo_d    = {quo_q[DW-2:0], fits};
                if (count_q == '0) begin
                    state_d = FIX;
                end else begin
                    count_d = count_q - 1'b1;
                end
            end
            FIX: begin
                divZero_d  = zero_q;
                overflow_d = 1'b0;
                if (zero_q) begin
                    remainder_d = '0;
`ifdef SDR_DIV_SATURATE_EN
                    quotient_d  = dvdNeg_q ? -QMAX : QMAX;
`else
                    quotient_d  = '0;
`endif
                end else if (!qNeg && quo_q[DW-1]) begin
                    // Only -2^(DW-1) / -1 yields a positive magnitude of 2^(DW-1).
                    overflow_d  = 1'b1;
                    remainder_d = '0;
`ifdef SDR_DIV_SATURATE_EN
                    quotient_d  = QMAX;
`else
                    quotient_d  = quo_q;
`endif
                end else begin
                    quotient_d  = qNeg ? -quo_q : quo_q;
                    remainder_d = dvdNeg_q ? -remLow : remLow;
                end
                outValid_d = 1'b1;
                state_d    = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    outValid_d = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE) && reset;
    assign out_valid = outValid_q;
    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign div_zero  = divZero_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_sdr_seq_divider.sv
// Scoreboard bench for sdr_seq_divider: directed operands, expected results queued at issue
// and checked by a monitor when the result handshake completes.
module tb_sdr_seq_divider;

    typedef struct {
        int q;
        int r;
        int dz;
        int ov;
    } exp_t;

    logic               clk = 1'b0;
    logic               reset;
    logic               ce;
    logic               inValid;
    logic               inReady;
    logic signed [19:0] dividend;
    logic signed [9:0]  divisor;
    logic               outValid;
    logic               outReady;
    logic signed [19:0] quotient;
    logic signed [9:0]  remainder;
    logic               divZero;
    logic               overflow;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    exp_t mon;

    sdr_seq_divider #(.DW(20), .VW(10)) dut (
        .clk       (clk),
        .reset     (reset),
        .ce        (ce),
        .in_valid  (inValid),
        .in_ready  (inReady),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (outValid),
        .out_ready (outReady),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (divZero),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Issue one operation, queue its expected result and measure enabled-cycle latency.
    task automatic applyStimulus(input int dvd, input int dvs, input int eq, input int er,
                                 input int edz, input int eov, input bit toggleCe,
                                 input bit holdReady);
        int waitCnt = 0;
        int lat     = 0;
        int enabled = 0;
        exp_t e;
        while (!inReady && waitCnt < 100) begin
            @(posedge clk);
            #1;
            waitCnt++;
        end
        checkOutput("in_ready_before_issue", int'(inReady), 1);
        e.q = eq; e.r = er; e.dz = edz; e.ov = eov;
        sb.push_back(e);
        outReady = !holdReady;
        ce       = 1'b1;
        dividend = 20'(dvd);
        divisor  = 10'(dvs);
        inValid  = 1'b1;
        @(posedge clk);
        #1;
        inValid  = 1'b0;
        dividend = 20'($urandom);
        divisor  = 10'($urandom);
        while (!outValid && lat < 200) begin
            if (toggleCe) ce = (lat % 2 == 1);
            @(posedge clk);
            if (ce) enabled++;
            #1;
            lat++;
        end
        ce = 1'b1;
        checkOutput("latency", enabled, 21);
    endtask

    // Monitor: compare whenever a result is actually handed over.
    always @(negedge clk) begin
        if (reset && outValid && outReady && ce) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_result: got q=%0d expected none", quotient);
            end else begin
                mon = sb.pop_front();
                checkOutput("quotient", int'(quotient), mon.q);
                checkOutput("remainder", int'(remainder), mon.r);
                checkOutput("div_zero", int'(divZero), mon.dz);
                checkOutput("overflow", int'(overflow), mon.ov);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: got no finish expected finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        bit seen;
        reset    = 1'b0;
        ce       = 1'b1;
        inValid  = 1'b0;
        outReady = 1'b1;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("in_ready_in_reset", int'(inReady), 0);
        reset = 1'b1;
        #1;
        checkOutput("reset_in_ready", int'(inReady), 1);
        checkOutput("reset_out_valid", int'(outValid), 0);
        checkOutput("reset_quotient", int'(quotient), 0);
        checkOutput("reset_remainder", int'(remainder), 0);
        checkOutput("reset_div_zero", int'(divZero), 0);
        checkOutput("reset_overflow", int'(overflow), 0);

        applyStimulus(1000, 7, 142, 6, 0, 0, 0, 0);
        applyStimulus(-1000, 7, -142, -6, 0, 0, 0, 0);
        applyStimulus(1000, -7, -142, 6, 0, 0, 0, 0);
        applyStimulus(524287, -1, -524287, 0, 0, 0, 0, 0);
`ifdef SDR_DIV_SATURATE_EN
        applyStimulus(-524288, -1, 524287, 0, 0, 1, 0, 0);
        applyStimulus(-300, 0, -524287, 0, 1, 0, 0, 0);
`else
        applyStimulus(-524288, -1, -524288, 0, 0, 1, 0, 0);
        applyStimulus(-300, 0, 0, 0, 1, 0, 0, 0);
`endif

        // Backpressure: result must sit still while the consumer stalls.
        applyStimulus(-1000, -7, 142, -6, 0, 0, 0, 1);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            checkOutput("hold_out_valid", int'(outValid), 1);
            checkOutput("hold_in_ready", int'(inReady), 0);
            checkOutput("hold_quotient", int'(quotient), 142);
            checkOutput("hold_remainder", int'(remainder), -6);
        end
        outReady = 1'b1;
        @(posedge clk);
        #1;
        outReady = 1'b0;
        checkOutput("release_in_ready", int'(inReady), 1);
        checkOutput("release_out_valid", int'(outValid), 0);
        outReady = 1'b1;

        applyStimulus(12345, -123, -100, 45, 0, 0, 1, 0);

        // Reset in the middle of a calculation abandons it silently.
        while (!inReady) begin
            @(posedge clk);
            #1;
        end
        dividend = 20'd5000;
        divisor  = 10'd3;
        inValid  = 1'b1;
        @(posedge clk);
        #1;
        inValid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        checkOutput("midreset_out_valid", int'(outValid), 0);
        checkOutput("midreset_in_ready", int'(inReady), 1);
        seen = 1'b0;
        repeat (25) begin
            @(posedge clk);
            #1;
            if (outValid) seen = 1'b1;
        end
        checkOutput("midreset_no_result", int'(seen), 0);

        applyStimulus(9, 3, 3, 0, 0, 0, 0, 0);

        repeat (4) @(posedge clk);
        #1;
        checkOutput("scoreboard_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sdr_seq_divider.md
Name: sdr_seq_divider

Overview:
- Sequential signed divider for the sdr_periph datapath; the inverse of the registered 10x10 signed multiplier used on the mixer path.
- Takes a DW-bit signed product-domain value and a VW-bit signed divisor. Typical uses are gain normalisation and AGC scaling.
- Restoring radix-2 algorithm, one quotient bit per enabled clock.
- valid/ready handshake on both input and output.

Parameters:
- DW, 20, dividend and quotient width (signed, two's complement)
- VW, 10, divisor and remainder width (signed, two's complement)

Ports:
- clk  in  1  system clock; all state changes on the rising edge
- reset  in  1  synchronous, active-low reset
- ce  in  1  clock enable; when low, all state, counters and outputs hold
- in_valid  in  1  dividend/divisor present
- in_ready  out  1  high only in IDLE
- dividend  in  DW  signed dividend
- divisor  in  VW  signed divisor
- out_valid  out  1  result valid; held until accepted
- out_ready  in  1  downstream accepts result
- quotient  out  DW  signed quotient
- remainder  out  VW  signed remainder
- div_zero  out  1  divisor was 0; valid with out_valid
- overflow  out  1  quotient not representable; valid with out_valid

Behaviour:
- Reset (reset==0 at a clk edge, regardless of ce): state=IDLE; out_valid=0; quotient=0; remainder=0; div_zero=0; overflow=0; iteration counter=0. Reset mid-operation abandons the operation and produces no output.
- in_ready is combinational: (state==IDLE) && reset. All other outputs are registered.
- States:
  - IDLE: on in_valid && ce, latch |dividend| and |divisor| (DW+1-bit magnitudes), the sign of each operand, and the zero flag; go to CALC with counter=DW-1.
  - CALC: each ce edge, shift the partial remainder left and bring in the next dividend bit. Trial-subtract |divisor|; if the result is non-negative, keep it and set the quotient bit to 1, else restore. At counter==0 go to FIX, otherwise decrement the counter.
  - FIX: apply signs. Quotient is negative iff the operand signs differ; it truncates toward zero. Remainder takes the sign of the dividend. Apply the zero and overflow rules below, then load the outputs, set out_valid=1 and go to DONE.
  - DONE: hold all outputs. On out_ready && ce, clear out_valid and go to IDLE. A new operand cannot be accepted on the same edge.
- Latency: input accepted at edge k gives out_valid high after edge k+DW+1 (21 ce-cycles for DW=20). Minimum initiation interval is DW+3 cycles. ce low stretches latency cycle-for-cycle.
- Remainder fits in VW bits by construction: |rem| < |divisor| <= 2^(VW-1).
- Divide by zero: div_zero=1, quotient=0, remainder=0, overflow=0. Still takes full latency.
- Overflow: only dividend = -2^(DW-1) with divisor = -1. Sets overflow=1; quotient wraps to -2^(DW-1); remainder=0.
- Input ports are sampled only at the accept edge; later changes have no effect.
- out_ready in IDLE/CALC/FIX is ignored. in_valid outside IDLE is ignored; the source must hold it until in_ready.

Optional Feature:
- Macro: SDR_DIV_SATURATE_EN.
- Defined:
  - Divide by zero: quotient saturates to +(2^(DW-1)-1) if the dividend is >= 0, else -(2^(DW-1)-1).
  - Overflow case: quotient = +(2^(DW-1)-1).
  - div_zero and overflow flags and remainder=0 are unchanged.
- Undefined: the zero and wrap results described in Behaviour. Latency is identical in both builds.

Test Plan:
1. dividend=1000, divisor=7 -> quotient=142, remainder=6, flags 0; out_valid rises exactly 21 cycles after the accept edge.
2. dividend=-1000, divisor=7 -> quotient=-142, remainder=-6. dividend=1000, divisor=-7 -> quotient=-142, remainder=6.
3. dividend=524287, divisor=-1 -> quotient=-524287, remainder=0, overflow=0. dividend=-524288, divisor=-1 -> overflow=1; quotient=-524288, or 524287 with SDR_DIV_SATURATE_EN.
4. dividend=-300, divisor=0 -> div_zero=1; quotient=0, or -524287 with SDR_DIV_SATURATE_EN; remainder=0.
5. Backpressure and ce:
   - Hold out_ready=0 for 10 cycles after out_valid: outputs stable, in_ready=0.
   - Then pulse out_ready: in_ready=1 next cycle.
   - Toggle ce 50% during CALC: latency is 21 enabled cycles and the result matches 12345/-123 = -100 r 45.
6. Assert reset=0 for one cycle mid-CALC -> out_valid stays 0 and in_ready=1 afterwards; next operation 9/3 -> quotient=3, remainder=0.
